// File: rtl/core_mmio_router.sv
// -----------------------------------------------------------------------------
// core_mmio_router
//
// Purpose:
//   Steers core data-side requests either to the counter/timer MMIO register
//   block or to the external data memory bus, and returns the response to the
//   core. Only one transaction is ever outstanding. The MMIO block answers a
//   fixed one cycle after grant, so its response is captured into a small
//   buffer in case the core is not ready to take it. Partial-width writes into
//   the MMIO region are not supported by the counter block; they are accepted
//   here and answered locally with an error response.
//
// Handshake semantics (all interfaces):
//   A request transfers on a cycle where *_req and *_gnt are both high.
//   A response transfers on a cycle where *_recv and *_ack are both high.
//   Requests are held stable by the initiator until granted. Grants and
//   response-valid may depend combinationally on the same-cycle request/ack.
//
// Ports:
//   g_clk, g_resetn        clock, synchronous active-low reset
//   cpu_*                  core load/store side (request in, response out)
//   mmio_*                 counter block side (fixed 1-cycle read latency)
//   mem_*                  external memory bus (variable latency)
//   dbg_state              current FSM state, for observation only
// -----------------------------------------------------------------------------
module core_mmio_router #(
    parameter int              AW             = 64,
    parameter int              DW             = 64,
    parameter logic [AW-1:0]   MMIO_BASE_ADDR = 64'h0000_0000_0001_0000,
    parameter logic [AW-1:0]   MMIO_SIZE_MASK = 64'h0000_0000_0000_FFFF
) (
    input  logic              g_clk,
    input  logic              g_resetn,

    // Core side
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [DW/8-1:0]   cpu_strb,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_recv,
    input  logic              cpu_ack,
    output logic [DW-1:0]     cpu_rdata,
    output logic              cpu_error,

    // Counter / timer MMIO block
    output logic              mmio_req,
    output logic              mmio_wen,
    output logic [AW-1:0]     mmio_addr,
    output logic [DW-1:0]     mmio_wdata,
    input  logic              mmio_gnt,
    input  logic [DW-1:0]     mmio_rdata,
    input  logic              mmio_error,

    // External memory bus
    output logic              mem_req,
    output logic              mem_wen,
    output logic [DW/8-1:0]   mem_strb,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_recv,
    output logic              mem_ack,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_error,

    // Observation
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MMIO_RSP  = 3'd1,
        MMIO_HOLD = 3'd2,
        ERR_RSP   = 3'd3,
        MEM_RSP   = 3'd4
    } state_t;

    state_t          state_q,     state_d;
    logic [DW-1:0]   buf_rdata_q, buf_rdata_d;
    logic            buf_error_q, buf_error_d;

    logic            addr_hit;
    logic            strb_full;

    // Region match: the low bits covered by the size mask are don't-care.
    assign addr_hit  = ((cpu_addr & ~MMIO_SIZE_MASK) == MMIO_BASE_ADDR);
    assign strb_full = &cpu_strb;

    assign dbg_state = state_q;

    // -------------------------------------------------------------------------
    // State and response buffer registers
    // -------------------------------------------------------------------------
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q     <= IDLE;
            buf_rdata_q <= '0;
            buf_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_rdata_q <= buf_rdata_d;
            buf_error_q <= buf_error_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        buf_rdata_d = buf_rdata_q;
        buf_error_d = buf_error_q;

        cpu_gnt     = 1'b0;
        cpu_recv    = 1'b0;
        cpu_rdata   = '0;
        cpu_error   = 1'b0;

        mmio_req    = 1'b0;
        mmio_wen    = 1'b0;
        mmio_addr   = '0;
        mmio_wdata  = '0;

        mem_req     = 1'b0;
        mem_wen     = 1'b0;
        mem_strb    = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_ack     = 1'b0;

        // While reset is asserted every output stays at zero, so the core
        // never sees a grant that the register reset would then discard.
        if (g_resetn) begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        if (addr_hit) begin
                            if (cpu_wen && !strb_full) begin
                                // Counter block only takes full-width writes:
                                // swallow the request and answer with an error.
                                cpu_gnt = 1'b1;
                                state_d = ERR_RSP;
                            end else begin
                                mmio_req   = 1'b1;
                                mmio_wen   = cpu_wen;
                                mmio_addr  = cpu_addr;
                                mmio_wdata = cpu_wdata;
                                cpu_gnt    = mmio_gnt;
                                if (mmio_gnt) begin
                                    state_d = MMIO_RSP;
                                end
                            end
                        end else begin
                            mem_req   = 1'b1;
                            mem_wen   = cpu_wen;
                            mem_strb  = cpu_strb;
                            mem_addr  = cpu_addr;
                            mem_wdata = cpu_wdata;
                            cpu_gnt   = mem_gnt;
                            if (mem_gnt) begin
                                state_d = MEM_RSP;
                            end
                        end
                    end
                end

                MMIO_RSP: begin
                    // The counter block only drives its response in this one
                    // cycle, so it is always captured in case the core stalls.
                    cpu_recv    = 1'b1;
                    cpu_rdata   = mmio_rdata;
                    cpu_error   = mmio_error;
                    buf_rdata_d = mmio_rdata;
                    buf_error_d = mmio_error;
                    state_d     = cpu_ack ? IDLE : MMIO_HOLD;
                end

                MMIO_HOLD: begin
                    cpu_recv  = 1'b1;
                    cpu_rdata = buf_rdata_q;
                    cpu_error = buf_error_q;
                    if (cpu_ack) begin
                        state_d = IDLE;
                    end
                end

                ERR_RSP: begin
                    cpu_recv  = 1'b1;
                    cpu_error = 1'b1;
                    if (cpu_ack) begin
                        state_d = IDLE;
                    end
                end

                MEM_RSP: begin
                    // Memory response flows straight through; data and error
                    // are masked while no response is valid.
                    cpu_recv = mem_recv;
                    mem_ack  = cpu_ack;
                    if (mem_recv) begin
                        cpu_rdata = mem_rdata;
                        cpu_error = mem_error;
                        if (cpu_ack) begin
                            state_d = IDLE;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/core_mmio_router.md
Name: core_mmio_router

Overview:
Routes core data-side memory requests to one of two targets: the counter/timer MMIO register block or the external data memory bus. It sits between the core load/store unit and those two targets, and returns responses to the core in order. At most one transaction is outstanding at a time. It buffers the fixed-latency MMIO response when the core stalls, and rejects partial-width MMIO writes locally.

Parameters:
MMIO_BASE_ADDR, 64'h0000_0000_0001_0000, base of counter MMIO region (must equal counter block base)
MMIO_SIZE_MASK, 64'h0000_0000_0000_FFFF, low address bits ignored for region match
AW, 64, address width
DW, 64, data width

Ports:
g_clk  in  1  global clock
g_resetn  in  1  synchronous active-low reset
cpu_req  in  1  core request valid
cpu_wen  in  1  core write enable
cpu_strb  in  DW/8  write byte strobes
cpu_addr  in  AW  request address
cpu_wdata  in  DW  write data
cpu_gnt  out  1  request accepted this cycle
cpu_recv  out  1  response valid
cpu_ack  in  1  core accepts response
cpu_rdata  out  DW  response read data
cpu_error  out  1  response error
mmio_req  out  1  counter block request
mmio_wen  out  1  counter block write enable
mmio_addr  out  AW  counter block address
mmio_wdata  out  DW  counter block write data
mmio_gnt  in  1  counter block grant
mmio_rdata  in  DW  counter read data (valid cycle after grant)
mmio_error  in  1  counter error (valid cycle after grant)
mem_req  out  1  memory request
mem_wen  out  1  memory write enable
mem_strb  out  DW/8  memory strobes
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_gnt  in  1  memory grant
mem_recv  in  1  memory response valid
mem_ack  out  1  response accepted
mem_rdata  in  DW  memory read data
mem_error  in  1  memory error

Behaviour:
- Region hit: hit = (cpu_addr & ~MMIO_SIZE_MASK) == MMIO_BASE_ADDR. With the defaults, 0x1_0000..0x1_FFFF hit; 0xFFFF and 0x2_0000 miss.
- FSM states: IDLE, MMIO_RSP, MMIO_HOLD, ERR_RSP, MEM_RSP. Reset state is IDLE.
- All outputs are 0 in reset and whenever their state condition is false. cpu_rdata is 0 whenever cpu_recv=0.
- IDLE, cpu_req && hit && cpu_wen && cpu_strb != all-ones:
  - cpu_gnt=1, no mmio_req.
  - Next state ERR_RSP.
- IDLE, cpu_req && hit, otherwise:
  - mmio_req=1; mmio_wen/addr/wdata pass through combinationally.
  - cpu_gnt=mmio_gnt. If granted, next state MMIO_RSP.
- IDLE, cpu_req && !hit:
  - mem_req=1; mem_wen/strb/addr/wdata pass through combinationally.
  - cpu_gnt=mem_gnt. If granted, next state MEM_RSP.
  - If not granted, the request is held by the core, and routing is re-evaluated each cycle.
- cpu_gnt=0 in every state except IDLE. mmio_req and mem_req are never asserted together.
- MMIO_RSP (exactly 1 cycle after grant):
  - cpu_recv=1; cpu_rdata=mmio_rdata; cpu_error=mmio_error.
  - Both values are also captured into the response buffer.
  - cpu_ack: next state IDLE; otherwise MMIO_HOLD.
- MMIO_HOLD:
  - cpu_recv=1, data and error driven from the buffer.
  - Buffer contents stay stable regardless of mmio_* inputs.
  - Leave to IDLE on cpu_ack.
- ERR_RSP:
  - cpu_recv=1, cpu_error=1, cpu_rdata=0.
  - Leave to IDLE on cpu_ack.
- MEM_RSP:
  - cpu_recv=mem_recv; cpu_rdata=mem_rdata; cpu_error=mem_error; mem_ack=cpu_ack.
  - Leave to IDLE when mem_recv && cpu_ack.
- Latency:
  - Minimum request-to-response is 1 cycle.
  - Minimum grant-to-next-grant is 2 cycles, since the response cycle and the following IDLE cycle are both needed.
- Reset mid-operation:
  - Next cycle is IDLE with all outputs 0, buffer cleared.
  - An outstanding memory transaction is abandoned.
- Simultaneous cpu_ack with response: the transaction retires the same cycle. A new cpu_req is evaluated only in the next IDLE cycle.

Test Plan:
- Read 0x1_0000 with mmio_rdata=64'h1234 in the response cycle, cpu_ack=1 -> mmio_req high for 1 cycle, cpu_recv the next cycle with rdata 64'h1234, mem_req never high.
- Write to 0x2000_0000 with mem_gnt low for 3 cycles -> mem_req and its payload stable for 4 cycles, cpu_gnt only in cycle 4; mem_recv 2 cycles later is passed to the core with mem_ack=cpu_ack.
- Write to 0x1_0008 with strb 8'h0F -> no mmio_req; next cycle cpu_recv=1, cpu_error=1, rdata 0.
- MMIO read returning 64'hAAAA with cpu_ack low for 3 cycles while mmio_rdata changes to 64'h5555 -> cpu_rdata holds 64'hAAAA until ack, then IDLE.
- Boundary addresses 0xFFFF, 0x1_FFFF, 0x2_0000 -> routed mem, mmio, mem respectively.
- Assert g_resetn=0 during MEM_RSP -> next cycle cpu_recv, mem_ack, mem_req and mmio_req all 0; a new cpu_req after reset is granted normally.
